// File: rtl/tl_ul_pkg.sv
// rtl/tl_ul_pkg.sv - TileLink-UL opcodes, D-channel response record and mask helper.
package tl_ul_pkg;

   localparam int SRC_W = 2;

   localparam logic [2:0] PUT_FULL        = 3'd0;
   localparam logic [2:0] PUT_PARTIAL     = 3'd1;
   localparam logic [2:0] GET             = 3'd4;

   localparam logic [2:0] ACCESS_ACK      = 3'd0;
   localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

   typedef struct packed {
      logic [2:0]       opcode;
      logic [1:0]       size;
      logic [SRC_W-1:0] source;
      logic             denied;
      logic [31:0]      data;
   } d_rsp_t;

   typedef enum logic {
      SLOT_EMPTY,
      SLOT_VALID
   } slot_state_t;

   // Byte lanes a naturally aligned access of 2**size bytes at this offset covers.
   function automatic logic [3:0] full_mask(input logic [1:0] size, input logic [1:0] offset);
      case (size)
         2'd0:    return 4'b0001 << offset;
         2'd1:    return offset[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/tl_ul_csr_slave_if.sv
// rtl/tl_ul_csr_slave_if.sv - TileLink-UL A/D channel bundle between the crossbar port and the CSR slave.
interface tl_ul_csr_slave_if #(
   parameter int SOURCE_W = 2
);
   logic                a_valid;
   logic                a_ready;
   logic [2:0]          a_opcode;
   logic [2:0]          a_param;
   logic [1:0]          a_size;
   logic [SOURCE_W-1:0] a_source;
   logic [11:0]         a_address;
   logic [3:0]          a_mask;
   logic [31:0]         a_data;

   logic                d_valid;
   logic                d_ready;
   logic [2:0]          d_opcode;
   logic [1:0]          d_size;
   logic [SOURCE_W-1:0] d_source;
   logic                d_denied;
   logic [31:0]         d_data;

   modport master (
      output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
      input  a_ready, d_valid, d_opcode, d_size, d_source, d_denied, d_data
   );

   modport slave (
      input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
      output a_ready, d_valid, d_opcode, d_size, d_source, d_denied, d_data
   );
endinterface

// File: rtl/tl_ul_rsp_fifo.sv
// rtl/tl_ul_rsp_fifo.sv - two-entry D-channel response queue.
// in_ready looks only at occupancy, so the upstream ready never depends on out_ready.
module tl_ul_rsp_fifo
   import tl_ul_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  d_rsp_t     in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output d_rsp_t     out_data,
   output logic [1:0] count
);
   slot_state_t slot_state [2];
   slot_state_t slot_next  [2];
   d_rsp_t      mem        [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic        push;
   logic        pop;

   assign count     = {1'b0, slot_state[0] == SLOT_VALID} + {1'b0, slot_state[1] == SLOT_VALID};
   assign in_ready  = (count != 2'd2);
   assign out_valid = (slot_state[rd_ptr] == SLOT_VALID);
   assign out_data  = out_valid ? mem[rd_ptr] : '0;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_comb begin
      slot_next = slot_state;
      if (push) slot_next[wr_ptr] = SLOT_VALID;
      if (pop)  slot_next[rd_ptr] = SLOT_EMPTY;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         slot_state[0] <= SLOT_EMPTY;
         slot_state[1] <= SLOT_EMPTY;
         wr_ptr        <= 1'b0;
         rd_ptr        <= 1'b0;
      end else begin
         slot_state <= slot_next;
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
      end
   end

   // Payload needs no reset: out_data is forced to zero whenever the head slot is empty.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= in_data;
   end

endmodule

// File: rtl/tl_ul_csr_slave.sv
// rtl/tl_ul_csr_slave.sv - TileLink-UL slave terminating Get/Put accesses on a bank of 32-bit CSRs.
module tl_ul_csr_slave
   import tl_ul_pkg::*;
#(
   parameter int                   SOURCE_W   = SRC_W,
   parameter int                   REG_COUNT  = 8,
   parameter logic [REG_COUNT-1:0] RO_MASK    = 8'h01,
   parameter logic [31:0]          RESET_VAL0 = 32'h0000_0000
)
(
   input  logic                     clock,
   input  logic                     reset_n,
   tl_ul_csr_slave_if.slave         tl,
   output logic [REG_COUNT-1:0]     reg_wr_pulse,
   output logic [32*REG_COUNT-1:0]  reg_q
);
   localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

   logic [31:0]      regs [REG_COUNT];
   logic             ready_q;
   logic [9:0]       index;
   logic [1:0]       offset;
   logic [IDX_W-1:0] reg_idx;
   logic             is_put;
   logic             is_get;
   logic             op_ok;
   logic             misaligned;
   logic             idx_bad;
   logic             mask_bad;
   logic             err;
   logic             fire;
   logic             wr_en;
   logic             fifo_in_ready;
   logic [1:0]       fifo_count;
   d_rsp_t           rsp_in;
   d_rsp_t           rsp_out;

   assign index   = tl.a_address[11:2];
   assign offset  = tl.a_address[1:0];
   assign reg_idx = index[IDX_W-1:0];

   assign is_put  = (tl.a_opcode == PUT_FULL) || (tl.a_opcode == PUT_PARTIAL);
   assign is_get  = (tl.a_opcode == GET);
   assign op_ok   = is_put || is_get;

   always_comb begin
      misaligned = 1'b1;
      case (tl.a_size)
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = offset[0];
         2'd2:    misaligned = |offset;
         default: misaligned = 1'b1;
      endcase
   end

   assign idx_bad  = (index >= 10'(REG_COUNT));
   assign mask_bad = (tl.a_opcode == PUT_FULL) && (tl.a_mask != full_mask(tl.a_size, offset));

   // Index is only trusted for the read-only lookup once it is known to be in range.
   assign err = !op_ok || (tl.a_param != 3'd0) || (tl.a_size == 2'd3) || misaligned ||
                idx_bad || mask_bad || (is_put && !idx_bad && RO_MASK[reg_idx]);

   // ready_q keeps a_ready low until the first clock edge after reset is released.
   assign tl.a_ready = ready_q && (fifo_count != 2'd2);
   assign fire       = tl.a_valid && ready_q && fifo_in_ready;
   assign wr_en      = fire && is_put && !err;

   always_comb begin
      rsp_in        = '0;
      rsp_in.opcode = is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
      rsp_in.size   = tl.a_size;
      rsp_in.source = SRC_W'(tl.a_source);
      rsp_in.denied = err;
      rsp_in.data   = (is_get && !err) ? regs[reg_idx] : 32'h0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ready_q <= 1'b0;
      end else begin
         ready_q <= 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs[i] <= (i == 0) ? RESET_VAL0 : 32'h0;
         end
         reg_wr_pulse <= '0;
      end else begin
         reg_wr_pulse <= '0;
         if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
               if (tl.a_mask[b]) regs[reg_idx][8*b +: 8] <= tl.a_data[8*b +: 8];
            end
            reg_wr_pulse[reg_idx] <= 1'b1;
         end
      end
   end

   generate
      for (genvar g = 0; g < REG_COUNT; g++) begin : g_reg_q
         assign reg_q[32*g +: 32] = regs[g];
      end
   endgenerate

   tl_ul_rsp_fifo u_rsp_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (fire),
      .in_ready  (fifo_in_ready),
      .in_data   (rsp_in),
      .out_valid (tl.d_valid),
      .out_ready (tl.d_ready),
      .out_data  (rsp_out),
      .count     (fifo_count)
   );

   assign tl.d_opcode = rsp_out.opcode;
   assign tl.d_size   = rsp_out.size;
   assign tl.d_source = SOURCE_W'(rsp_out.source);
   assign tl.d_denied = rsp_out.denied;
   assign tl.d_data   = rsp_out.data;

endmodule
